// File: rtl/noc_ni_packetizer_pkg.sv
// Shared definitions for the NoC network-interface packetizer.
// - Flit layout: 8 bits, {type[1:0], body[5:0]}.
// - Flit type codes BODY/HEAD/TAIL/HTAIL.
// - Packetizer FSM state encodings IDLE/HEAD/PAYLOAD.
// - mk_flit(): assembles a flit from its type and body fields.
// No ports (package only).
package noc_ni_packetizer_pkg;

  localparam int FLIT_W   = 8;
  localparam int TYPE_MSB = 7;
  localparam int TYPE_LSB = 6;
  localparam int BODY_W   = 6;

  localparam logic [1:0] FT_BODY  = 2'b00;
  localparam logic [1:0] FT_HEAD  = 2'b01;
  localparam logic [1:0] FT_TAIL  = 2'b10;
  localparam logic [1:0] FT_HTAIL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEAD    = 2'd1,
    ST_PAYLOAD = 2'd2
  } state_e;

  function automatic logic [FLIT_W-1:0] mk_flit(input logic [1:0]        ftype,
                                                input logic [BODY_W-1:0] body);
    return {ftype, body};
  endfunction

endpackage

// File: rtl/noc_credit_cnt.sv
// Credit counter for the downstream router buffer.
// Ports:
//   clk, rst   clock, asynchronous active-high reset (count -> BUF_DEPTH)
//   i_inc      credit returned by the buffer (one per flit read out)
//   i_dec      credit consumed (one per flit written)
//   o_count    current credit count
//   o_err      sticky: a credit arrived while the count was already full
module noc_credit_cnt #(
  parameter int BUF_DEPTH = 16,
  parameter int CW        = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_inc,
  input  logic          i_dec,
  output logic [CW-1:0] o_count,
  output logic          o_err
);

  localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);

  logic [CW-1:0] r_count;
  logic          r_err;

  // Simultaneous inc and dec cancel out; a surplus credit at FULL is
  // dropped and flagged rather than wrapping the counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= FULL;
      r_err   <= 1'b0;
    end else begin
      case ({i_inc, i_dec})
        2'b10: begin
          if (r_count == FULL) r_err   <= 1'b1;
          else                 r_count <= r_count + 1'b1;
        end
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_err   = r_err;

endmodule

// File: rtl/noc_ni_packetizer.sv
// NoC network-interface packetizer: turns a packet request plus a 6-bit
// payload stream into head/body/tail flits for a router input buffer,
// under credit-based flow control.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   req_valid/req_ready       packet request handshake (ready only in IDLE)
//   req_dest_x/y, req_len     destination and payload flit count (clamped to MAX_LEN)
//   data_valid/data_ready     payload handshake (ready in PAYLOAD with credits)
//   data_in                   payload word
//   flit_out, wr_en           registered flit and write strobe to the router buffer
//   credit_in                 one pulse per flit drained from the router buffer
//   credits, cred_err         credit count and sticky credit-overflow flag
//   pkt_cnt                   (only with NI_PKT_STATS_EN) completed packet count
// Build option: define NI_PKT_STATS_EN to add the pkt_cnt output and counter.
module noc_ni_packetizer
  import noc_ni_packetizer_pkg::*;
#(
  parameter int BUF_DEPTH = 16,
  parameter int MAX_LEN   = 15,
  parameter int CW        = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_dest_x,
  input  logic [2:0]        req_dest_y,
  input  logic [3:0]        req_len,
  input  logic              data_valid,
  output logic              data_ready,
  input  logic [BODY_W-1:0] data_in,
  output logic [FLIT_W-1:0] flit_out,
  output logic              wr_en,
  input  logic              credit_in,
  output logic [CW-1:0]     credits,
  output logic              cred_err
`ifdef NI_PKT_STATS_EN
  ,
  output logic [15:0]       pkt_cnt
`endif
);

  localparam logic [4:0] LEN_CAP = 5'(MAX_LEN);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [2:0]        r_dest_x;
  logic [2:0]        r_dest_y;
  logic [3:0]        r_len;
  logic [3:0]        r_remaining;
  logic [3:0]        w_rem_nxt;
  logic [3:0]        w_len_clamped;
  logic [FLIT_W-1:0] r_flit;
  logic [FLIT_W-1:0] w_flit_nxt;
  logic              r_wr_en;
  logic              w_emit;
  logic              w_accept;
  logic              w_cred_ok;

  assign w_cred_ok     = (credits != '0);
  assign req_ready     = (r_state == ST_IDLE);
  assign data_ready    = (r_state == ST_PAYLOAD) && w_cred_ok;
  assign w_accept      = req_valid && req_ready;
  assign w_len_clamped = ({1'b0, req_len} > LEN_CAP) ? LEN_CAP[3:0] : req_len;

  // Decision stage: choose next state and the flit to emit this cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_emit      = 1'b0;
    w_flit_nxt  = r_flit;
    w_rem_nxt   = r_remaining;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_nxt = ST_HEAD;
      end
      ST_HEAD: begin
        if (w_cred_ok) begin
          w_emit = 1'b1;
          if (r_len == 4'd0) begin
            w_flit_nxt  = mk_flit(FT_HTAIL, {r_dest_x, r_dest_y});
            w_state_nxt = ST_IDLE;
          end else begin
            w_flit_nxt  = mk_flit(FT_HEAD, {r_dest_x, r_dest_y});
            w_rem_nxt   = r_len;
            w_state_nxt = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (data_valid && data_ready) begin
          w_emit    = 1'b1;
          w_rem_nxt = r_remaining - 4'd1;
          if (r_remaining == 4'd1) begin
            w_flit_nxt  = mk_flit(FT_TAIL, data_in);
            w_state_nxt = ST_IDLE;
          end else begin
            w_flit_nxt  = mk_flit(FT_BODY, data_in);
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output stage: control state and the registered flit interface.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_flit  <= '0;
      r_wr_en <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_flit  <= w_flit_nxt;
      r_wr_en <= w_emit;
    end
  end

  // Request fields and the payload countdown are only meaningful once
  // the FSM has left IDLE, so they carry no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_dest_x <= req_dest_x;
      r_dest_y <= req_dest_y;
      r_len    <= w_len_clamped;
    end
    r_remaining <= w_rem_nxt;
  end

  assign flit_out = r_flit;
  assign wr_en    = r_wr_en;

  noc_credit_cnt #(
    .BUF_DEPTH (BUF_DEPTH),
    .CW        (CW)
  ) u_credit_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (credit_in),
    .i_dec   (w_emit),
    .o_count (credits),
    .o_err   (cred_err)
  );

`ifdef NI_PKT_STATS_EN
  logic [15:0] r_pkt_cnt;
  logic        w_last;

  // A flit emitted while heading back to IDLE is a TAIL or HTAIL.
  assign w_last = w_emit && (w_state_nxt == ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_pkt_cnt <= 16'd0;
    else if (w_last) r_pkt_cnt <= r_pkt_cnt + 16'd1;
  end

  assign pkt_cnt = r_pkt_cnt;
`endif

endmodule

// File: tb/tb_noc_ni_packetizer.sv
// Self-checking bench for noc_ni_packetizer: directed packets, expected
// flits queued at issue time and compared by an independent monitor.
module tb_noc_ni_packetizer;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_dest_x;
  logic [2:0] req_dest_y;
  logic [3:0] req_len;
  logic       data_valid;
  logic       data_ready;
  logic [5:0] data_in;
  logic [7:0] flit_out;
  logic       wr_en;
  logic       credit_in;
  logic [4:0] credits;
  logic       cred_err;
`ifdef NI_PKT_STATS_EN
  logic [15:0] pkt_cnt;
`endif

  noc_ni_packetizer dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_dest_x (req_dest_x),
    .req_dest_y (req_dest_y),
    .req_len    (req_len),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .data_in    (data_in),
    .flit_out   (flit_out),
    .wr_en      (wr_en),
    .credit_in  (credit_in),
    .credits    (credits),
    .cred_err   (cred_err)
`ifdef NI_PKT_STATS_EN
    ,
    .pkt_cnt    (pkt_cnt)
`endif
  );

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         wr_cnt = 0;
  int         wr_last_cyc = 0;
  int         acc_cyc = 0;
  bit         chk_hold = 1'b0;
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got timeout expected handshake", name);
  endtask

  // Monitor: every write strobe must match the next queued flit.
  always @(negedge clk) begin
    if (!rst && wr_en) begin
      wr_cnt++;
      wr_last_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL flit_unexpected: got %0h expected none", flit_out);
      end else begin
        chk("flit", flit_out, exp_q.pop_front());
      end
    end
    if (chk_hold) chk("cred_hold", credits, 16);
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [2:0] x, input logic [2:0] y,
                          input logic [3:0] l, input logic [7:0] head);
    bit ok = 1'b0;
    req_valid = 1'b1; req_dest_x = x; req_dest_y = y; req_len = l;
    exp_q.push_back(head);
    for (int n = 0; n < 200; n++) begin
      @(posedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    #1;
    req_valid = 1'b0;
    acc_cyc = cyc;
    if (!ok) timeout("req_handshake");
  endtask

  task automatic send_data(input logic [5:0] d, input logic [7:0] exp);
    bit ok = 1'b0;
    data_valid = 1'b1; data_in = d;
    exp_q.push_back(exp);
    for (int n = 0; n < 200; n++) begin
      @(posedge clk);
      if (data_ready) begin ok = 1'b1; break; end
    end
    #1;
    if (!ok) timeout("data_handshake");
  endtask

  task automatic pulse_credit(input int n);
    credit_in = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    credit_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    int head_cyc;
    rst = 1'b1; req_valid = 1'b0; req_dest_x = '0; req_dest_y = '0; req_len = '0;
    data_valid = 1'b0; data_in = '0; credit_in = 1'b0;
    idle(3);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_flit", flit_out, 8'h00);
    chk("rst_credits", credits, 16);
    chk("rst_cred_err", cred_err, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_data_ready", data_ready, 0);
    rst = 1'b0;
    idle(2);

    // Single-flit packet, dest (2,5).
    send_req(3'd2, 3'd5, 4'd0, 8'hD5);
    idle(3);
    chk("htail_latency", wr_last_cyc, acc_cyc + 1);
    chk("htail_count", wr_cnt, 1);
    chk("htail_credits", credits, 15);
    pulse_credit(1);
    chk("credit_return", credits, 16);

    // Three payload flits streamed back-to-back.
    w0 = wr_cnt;
    send_req(3'd2, 3'd5, 4'd3, 8'h55);
    head_cyc = acc_cyc + 1;
    send_data(6'h0A, 8'h0A);
    send_data(6'h0B, 8'h0B);
    send_data(6'h0C, 8'h8C);
    data_valid = 1'b0;
    idle(2);
    chk("b2b_count", wr_cnt - w0, 4);
    chk("b2b_span", wr_last_cyc - head_cyc, 3);
    chk("b2b_credits", credits, 12);
    pulse_credit(4);
    chk("b2b_cred_ret", credits, 16);

    // Drain to 4 credits, then a 6-flit packet stalls after 4 flits.
    send_req(3'd7, 3'd0, 4'd11, 8'h78);
    for (int i = 1; i <= 10; i++) send_data(6'(i), {2'b00, 6'(i)});
    send_data(6'h0B, 8'h8B);
    data_valid = 1'b0;
    idle(2);
    chk("drain_credits", credits, 4);
    w0 = wr_cnt;
    send_req(3'd1, 3'd3, 4'd5, 8'h4B);
    send_data(6'h21, 8'h21);
    send_data(6'h22, 8'h22);
    send_data(6'h23, 8'h23);
    data_valid = 1'b1; data_in = 6'h24;
    idle(4);
    chk("stall_count", wr_cnt - w0, 4);
    chk("stall_data_ready", data_ready, 0);
    chk("stall_credits", credits, 0);
    pulse_credit(1);
    send_data(6'h24, 8'h24);
    pulse_credit(1);
    send_data(6'h25, 8'hA5);
    data_valid = 1'b0;
    idle(2);
    chk("resume_count", wr_cnt - w0, 6);
    chk("resume_credits", credits, 0);
    pulse_credit(16);
    chk("refill_credits", credits, 16);
    chk("refill_no_err", cred_err, 0);

    // Credit returned on every emit cycle: count stays at 16.
    send_req(3'd4, 3'd6, 4'd2, 8'h66);
    credit_in = 1'b1;
    chk_hold = 1'b1;
    send_data(6'h3F, 8'h3F);
    send_data(6'h15, 8'h95);
    data_valid = 1'b0;
    credit_in = 1'b0;
    idle(2);
    chk_hold = 1'b0;
    chk("simul_no_err", cred_err, 0);

    // Surplus credit at full: count holds, sticky error.
    pulse_credit(1);
    chk("ovf_credits", credits, 16);
    chk("ovf_err", cred_err, 1);
    send_req(3'd0, 3'd0, 4'd0, 8'hC0);
    idle(3);
    chk("ovf_sticky", cred_err, 1);
    chk("ovf_pkt_credits", credits, 15);
    pulse_credit(1);
    chk("ovf_refill", credits, 16);
`ifdef NI_PKT_STATS_EN
    chk("pkt_cnt", pkt_cnt, 6);
`endif

    // Reset after head + one body: packet is abandoned.
    send_req(3'd2, 3'd5, 4'd3, 8'h55);
    send_data(6'h0A, 8'h0A);
    data_valid = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_wr_en", wr_en, 0);
    chk("mid_rst_credits", credits, 16);
    chk("mid_rst_err", cred_err, 0);
`ifdef NI_PKT_STATS_EN
    chk("mid_rst_pkt_cnt", pkt_cnt, 0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);
    chk("mid_rst_req_ready", req_ready, 1);
    w0 = wr_cnt;
    idle(5);
    chk("mid_rst_no_tail", wr_cnt, w0);
    chk("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
